block_mem: RTL and testbench

- Parametrised main-memory model; successor to the fixed 4-word, fixed-delay memory used behind the data cache.
- Serves cache refills (block reads), write-through stores (word writes) and write-back evictions (block writes).
- Uses a valid/ready request/response handshake, a configurable access latency and a one-request-in-flight FSM.
- Synthesisable: all delay is counter-based, with no timing controls inside procedural assignments.

---
 rtl/block_mem_pkg.sv | 14 +
 rtl/block_mem_lat_cnt.sv | 33 +++
 rtl/block_mem.sv | 165 ++++++++++++++++
 tb/tb_block_mem.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/block_mem_pkg.sv
// block_mem_pkg: shared state type and block-alignment helper for block_mem.
package block_mem_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} mem_state_t;

   // Clear the low ow bits of a word address to get the aligned block base.
   function automatic logic [31:0] blk_base(input logic [31:0] addr, input int unsigned ow);
      logic [31:0] mask;
      mask = '1;
      mask = mask << ow;
      return addr & mask;
   endfunction

endpackage

// File: rtl/block_mem_lat_cnt.sv
// block_mem_lat_cnt: loadable down-counter with zero flag. Loads LATENCY-1,
// decrements on dec and saturates at zero.
module block_mem_lat_cnt #(
   parameter int unsigned LATENCY = 4
) (
   input  logic clk,
   input  logic rstn,
   input  logic load,
   input  logic dec,
   output logic zero
);

   localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   logic [CW-1:0] cnt;

   // Counter register: load has priority over decrement.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= CW'(LATENCY - 1);
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   // Zero flag.
   always_comb begin
      zero = (cnt == '0);
   end

endmodule

// File: rtl/block_mem.sv
// block_mem: parametrised main-memory model with valid/ready handshake,
// counter-based access latency and one request in flight.
// Optional byte strobes for word writes: define BLOCK_MEM_BYTE_EN_EN.
module block_mem
   import block_mem_pkg::*;
#(
   parameter int unsigned WIDTH           = 32,
   parameter int unsigned DEPTH           = 1024,
   parameter int unsigned WORDS_PER_BLOCK = 4,
   parameter int unsigned LATENCY         = 4,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned BW = WIDTH * WORDS_PER_BLOCK
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic             req_blk,
   input  logic [AW-1:0]    req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   input  logic [BW-1:0]    req_wblock,
`ifdef BLOCK_MEM_BYTE_EN_EN
   input  logic [WIDTH/8-1:0] req_wstrb,
`endif
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic             resp_is_wr,
   output logic [BW-1:0]    resp_rblock
);

   localparam int unsigned OW  = $clog2(WORDS_PER_BLOCK);
   localparam int unsigned NB  = WIDTH / 8;
   localparam int unsigned WPB = WORDS_PER_BLOCK;

   mem_state_t state, state_nx;

   logic [WIDTH-1:0] mem [DEPTH];

   logic             cap_we;
   logic             cap_blk;
   logic [AW-1:0]    cap_addr;
   logic [WIDTH-1:0] cap_wdata;
   logic [BW-1:0]    cap_wblock;
   logic [NB-1:0]    cap_wstrb;
   logic [NB-1:0]    strb_in;
   logic [AW-1:0]    addr_in;

   logic accept;
   logic finish;
   logic cnt_dec;
   logic cnt_zero;

   block_mem_lat_cnt #(
      .LATENCY (LATENCY)
   ) u_lat_cnt (
      .clk  (clk),
      .rstn (rstn),
      .load (accept),
      .dec  (cnt_dec),
      .zero (cnt_zero)
   );

   // Strobe source: real strobes when enabled, otherwise every byte.
   always_comb begin
`ifdef BLOCK_MEM_BYTE_EN_EN
      strb_in = req_wstrb;
`else
      strb_in = '1;
`endif
   end

   // Captured address: full address for word writes, aligned base otherwise.
   always_comb begin
      addr_in = AW'(blk_base(32'(req_addr), OW));
      if (req_we && !req_blk) begin
         addr_in = req_addr;
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_nx   = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      accept     = 1'b0;
      finish     = 1'b0;
      cnt_dec    = 1'b0;
      unique case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept   = 1'b1;
               state_nx = BUSY;
            end
         end
         BUSY: begin
            cnt_dec = 1'b1;
            if (cnt_zero) begin
               finish   = 1'b1;
               state_nx = RESP;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // State, request capture and response registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         cap_we      <= 1'b0;
         cap_blk     <= 1'b0;
         cap_addr    <= '0;
         cap_wdata   <= '0;
         cap_wblock  <= '0;
         cap_wstrb   <= '0;
         resp_is_wr  <= 1'b0;
         resp_rblock <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            cap_we     <= req_we;
            cap_blk    <= req_blk;
            cap_addr   <= addr_in;
            cap_wdata  <= req_wdata;
            cap_wblock <= req_wblock;
            cap_wstrb  <= strb_in;
         end
         if (finish) begin
            resp_is_wr <= cap_we;
            if (!cap_we) begin
               for (int unsigned i = 0; i < WPB; i++) begin
                  resp_rblock[i*WIDTH +: WIDTH] <= mem[cap_addr | AW'(i)];
               end
            end
         end
      end
   end

   // Storage array: not reset; written only in the final BUSY cycle, so a
   // reset during BUSY (which forces IDLE) cancels the pending write.
   always_ff @(posedge clk) begin
      if (finish && cap_we) begin
         if (cap_blk) begin
            for (int unsigned i = 0; i < WPB; i++) begin
               mem[cap_addr | AW'(i)] <= cap_wblock[i*WIDTH +: WIDTH];
            end
         end else begin
            for (int unsigned b = 0; b < NB; b++) begin
               if (cap_wstrb[b]) begin
                  mem[cap_addr][b*8 +: 8] <= cap_wdata[b*8 +: 8];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_block_mem.sv
// tb_block_mem: directed and randomized checks of block_mem against a
// word-level reference memory kept in the bench.
module tb_block_mem;

   localparam int AW = 10;
   localparam int W  = 32;
   localparam int BW = 128;
   localparam int LAT = 4;
`ifdef BLOCK_MEM_BYTE_EN_EN
   localparam bit BE = 1'b1;
`else
   localparam bit BE = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic          req_blk = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [W-1:0]  req_wdata = '0;
   logic [BW-1:0] req_wblock = '0;
`ifdef BLOCK_MEM_BYTE_EN_EN
   logic [3:0]    req_wstrb = '0;
`endif
   logic          resp_valid;
   logic          resp_ready = 1'b0;
   logic          resp_is_wr;
   logic [BW-1:0] resp_rblock;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] ref_mem [int];

   always #5 clk = ~clk;

   block_mem dut (
      .clk         (clk),
      .rstn        (rstn),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_blk     (req_blk),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_wblock  (req_wblock),
`ifdef BLOCK_MEM_BYTE_EN_EN
      .req_wstrb   (req_wstrb),
`endif
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_is_wr  (resp_is_wr),
      .resp_rblock (resp_rblock)
   );

   task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected block read from the reference memory.
   function automatic logic [BW-1:0] ref_block(input int addr);
      logic [BW-1:0] r;
      int base;
      base = addr - (addr % 4);
      r = '0;
      for (int i = 0; i < 4; i++) r[i*W +: W] = ref_mem[base + i];
      return r;
   endfunction

   // Apply a request's effect to the reference memory.
   task automatic ref_write(input logic blk, input int addr, input logic [W-1:0] wd,
                            input logic [BW-1:0] wb, input logic [3:0] strb);
      int base;
      logic [W-1:0] old;
      if (blk) begin
         base = addr - (addr % 4);
         for (int i = 0; i < 4; i++) ref_mem[base + i] = wb[i*W +: W];
      end else begin
         old = ref_mem.exists(addr) ? ref_mem[addr] : '0;
         for (int b = 0; b < 4; b++)
            if (!BE || strb[b]) old[b*8 +: 8] = wd[b*8 +: 8];
         ref_mem[addr] = old;
      end
   endtask

   // Full transaction: accept, measure latency, handshake, check turnaround.
   task automatic issue(input logic we, input logic blk, input int addr,
                        input logic [W-1:0] wd, input logic [BW-1:0] wb,
                        input logic [3:0] strb, output logic [BW-1:0] rb);
      int lat;
      bit ok;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_blk = blk; req_addr = AW'(addr);
      req_wdata = wd; req_wblock = wb;
`ifdef BLOCK_MEM_BYTE_EN_EN
      req_wstrb = strb;
`endif
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (req_ready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      chk("accept_wait", ok, 1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0; ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); lat++; #1;
         if (resp_valid) begin ok = 1'b1; break; end
      end
      chk("resp_wait", ok, 1);
      chk("latency", lat, LAT);
      chk("is_wr", resp_is_wr, we);
      rb = resp_rblock;
      if (we) ref_write(blk, addr, wd, wb, strb);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      chk("valid_drop", resp_valid, 0);
      chk("ready_rise", req_ready, 1);
   endtask

   initial begin
      logic [BW-1:0] rb, exp_blk, held;
      logic [W-1:0]  rd;
      int a;
      bit ok;

      // Reset for 3 cycles.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_rblock", resp_rblock, '0);
      chk("rst_is_wr", resp_is_wr, 0);
      @(negedge clk); rstn = 1'b1;

      // Block read of preloaded words.
      for (int i = 0; i < 4; i++)
         issue(1, 0, 'h40 + i, 32'hA0 + 32'(i), '0, 4'hF, rb);
      issue(0, 0, 'h42, '0, '0, 4'hF, rb);
      chk("blk_read", rb, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
      chk("blk_read_model", rb, ref_block('h42));

      // Word write into a known block, then read back.
      issue(1, 1, 'h104, '0, {32'h44, 32'h33, 32'h22, 32'h11}, 4'hF, rb);
      chk("wr_keeps_rblock", rb, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
      issue(1, 0, 'h105, 32'hDEADBEEF, '0, 4'hF, rb);
      issue(0, 0, 'h104, '0, '0, 4'hF, rb);
      chk("word_write_read", rb, {32'h44, 32'h33, 32'hDEADBEEF, 32'h11});

      // Backpressure with a pending second request.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_blk = 1'b0; req_addr = 'h40;
      @(posedge clk); #1;
      req_addr = 'h104;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (resp_valid) begin ok = 1'b1; break; end
      end
      chk("bp_resp_wait", ok, 1);
      held = resp_rblock;
      chk("bp_data", held, ref_block('h40));
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid_hold", resp_valid, 1);
         chk("bp_data_hold", resp_rblock, held);
         chk("bp_req_ready_low", req_ready, 0);
         @(posedge clk); #1;
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      chk("bp_hs_valid_drop", resp_valid, 0);
      chk("bp_hs_ready_rise", req_ready, 1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("bp_next_accepted", req_ready, 0);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (resp_valid) begin ok = 1'b1; break; end
      end
      chk("bp_next_resp_wait", ok, 1);
      chk("bp_next_data", resp_rblock, ref_block('h104));
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;

      // Block write interrupted by reset must not land.
      issue(1, 1, 'h200, '0, {32'h5555, 32'h4444, 32'h3333, 32'h2222}, 4'hF, rb);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_blk = 1'b1; req_addr = 'h200;
      req_wblock = {4{32'hFFFF0000}};
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b0;
      #1;
      chk("midrst_resp_valid", resp_valid, 0);
      chk("midrst_req_ready", req_ready, 1);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      issue(0, 0, 'h200, '0, '0, 4'hF, rb);
      chk("midrst_old_data", rb, {32'h5555, 32'h4444, 32'h3333, 32'h2222});

      // Byte strobes on a word write.
      issue(1, 0, 'h10, 32'h11223344, '0, 4'hF, rb);
      issue(1, 0, 'h10, 32'hAABBCCDD, '0, 4'b0101, rb);
      issue(0, 0, 'h10, '0, '0, 4'hF, rb);
      rd = rb[W-1:0];
      chk("strobe_model", rd, ref_mem['h10]);
`ifdef BLOCK_MEM_BYTE_EN_EN
      chk("strobe_word", rd, 32'h11BB33DD);
      issue(1, 0, 'h11, 32'h99999999, '0, 4'b0000, rb);
      issue(0, 0, 'h10, '0, '0, 4'hF, rb);
      chk("strobe_zero", rb, ref_block('h10));
`endif

      // Randomized traffic over a preloaded window.
      for (int b = 0; b < 8; b++)
         issue(1, 1, 'h300 + 4 * b, '0,
               {$urandom(), $urandom(), $urandom(), $urandom()}, 4'hF, rb);
      for (int n = 0; n < 40; n++) begin
         a = 'h300 + int'($urandom_range(0, 31));
         case ($urandom_range(0, 2))
            0: begin
               exp_blk = ref_block(a);
               issue(0, 0, a, '0, '0, 4'hF, rb);
               chk("rand_read", rb, exp_blk);
            end
            1: issue(1, 0, a, $urandom(), '0, 4'($urandom_range(0, 15)), rb);
            default: issue(1, 1, a, '0,
                           {$urandom(), $urandom(), $urandom(), $urandom()}, 4'hF, rb);
         endcase
      end
      for (int b = 0; b < 8; b++) begin
         exp_blk = ref_block('h300 + 4 * b);
         issue(0, 0, 'h300 + 4 * b, '0, '0, 4'hF, rb);
         chk("rand_final", rb, exp_blk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
